// File: rtl/gf2m_proj2aff571_pkg.sv
// Shared GF(2^571) definitions for the projective-to-affine converter
// and the field arithmetic blocks it uses.
//   M               field degree
//   FIELD_POLY      x^571 + x^10 + x^5 + x^2 + 1 (M+1 bits)
//   POLY_LOW        FIELD_POLY without the leading x^571 term
//   MUL_LAT_DEFAULT default multiplier latency in cycles
//   conv_state_t    converter FSM states
//   gf_xtime()      multiply an element by x, reduced
package gf571_pkg;

    localparam int M = 571;
    localparam logic [M:0]   FIELD_POLY = {1'b1, 560'b0, 11'h425};
    localparam logic [M-1:0] POLY_LOW   = FIELD_POLY[M-1:0];

    localparam int MUL_LAT_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        INV_WAIT,
        MUL_X,
        MUL_X_W,
        MUL_Y,
        MUL_Y_W,
        FIN
    } conv_state_t;

    // Shifting out bit 570 stands for x^571, which folds back as POLY_LOW.
    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
        gf_xtime = {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY_LOW : '0);
    endfunction

endpackage

// File: rtl/gf2m_proj2aff571_if.sv
// Bus bundle of the projective-to-affine converter: the request/result
// side toward the scalar-multiplication core and the start/done side
// toward the shared inverter.
//   start, X, Y, Z           conversion request and projective point
//   x_aff, y_aff, done, err  affine result, done pulse, point-at-infinity flag
//   busy                     converter not idle
//   inv_start, inv_a         inverter request and operand
//   inv_result, inv_done     inverter result and done level
// slave = the converter, master = its environment.
interface gf2m_proj2aff571_if;
    import gf571_pkg::*;

    logic         start;
    logic [M-1:0] X;
    logic [M-1:0] Y;
    logic [M-1:0] Z;
    logic [M-1:0] x_aff;
    logic [M-1:0] y_aff;
    logic         done;
    logic         err;
    logic         busy;
    logic         inv_start;
    logic [M-1:0] inv_a;
    logic [M-1:0] inv_result;
    logic         inv_done;

    modport slave (
        input  start, X, Y, Z, inv_result, inv_done,
        output x_aff, y_aff, done, err, busy, inv_start, inv_a
    );

    modport master (
        output start, X, Y, Z, inv_result, inv_done,
        input  x_aff, y_aff, done, err, busy, inv_start, inv_a
    );

endinterface

// File: rtl/gf2m_mult571.sv
// GF(2^571) polynomial-basis multiplier with a fixed output latency.
//   clk, rst  clock and synchronous active-high reset
//   a, b      operands (expected to come from registers)
//   p         a*b mod FIELD_POLY, valid LAT-1 cycles after a/b change,
//             so a result read LAT cycles after the operand-register
//             load reflects those operands
module gf2m_mult571
    import gf571_pkg::*;
#(
    parameter int LAT = MUL_LAT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);

    logic [M-1:0] p_comb;

    // MSB-first shift-and-add, reducing on every shift.
    always_comb begin
        p_comb = '0;
        for (int i = M - 1; i >= 0; i--) begin
            p_comb = gf_xtime(p_comb);
            if (b[i]) begin
                p_comb = p_comb ^ a;
            end
        end
    end

    generate
        if (LAT <= 1) begin : g_comb
            assign p = p_comb;
        end else begin : g_pipe
            logic [M-1:0] stage [LAT-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < LAT - 1; k++) begin
                        stage[k] <= '0;
                    end
                end else begin
                    stage[0] <= p_comb;
                    for (int k = 1; k < LAT - 1; k++) begin
                        stage[k] <= stage[k-1];
                    end
                end
            end

            assign p = stage[LAT-2];
        end
    endgenerate

endmodule

// File: rtl/squerer_571.sv
// Combinational GF(2^571) squarer.
//   a  input element
//   y  a^2 mod FIELD_POLY
module squerer_571
    import gf571_pkg::*;
(
    input  logic [M-1:0] a,
    output logic [M-1:0] y
);

    logic [2*M-2:0] wide;

    always_comb begin
        wide = '0;
        // Squaring in GF(2) just spreads the bits to even positions.
        for (int i = 0; i < M; i++) begin
            wide[2*i] = a[i];
        end
        // Fold x^i (i >= 571) into x^(i-571) * (x^10 + x^5 + x^2 + 1);
        // descending order so folded-in high bits are handled later.
        for (int i = 2 * M - 2; i >= M; i--) begin
            if (wide[i]) begin
                wide[i]          = 1'b0;
                wide[i - M + 10] = ~wide[i - M + 10];
                wide[i - M + 5]  = ~wide[i - M + 5];
                wide[i - M + 2]  = ~wide[i - M + 2];
                wide[i - M]      = ~wide[i - M];
            end
        end
        y = wide[M-1:0];
    end

endmodule

// File: rtl/gf2m_proj2aff571.sv
// Projective-to-affine converter for GF(2^571) points. Obtains Z^-1 from
// the shared inverter over the inv_* handshake, then computes
// x = X*Z^-1 and y = Y*Z^-1 (COORD=0) or y = Y*Z^-2 (COORD=1, Lopez-Dahab).
//   clk, rst  clock and synchronous active-high reset
//   bus       gf2m_proj2aff571_if.slave: request, result, inverter handshake
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; X/Y/Z latched on the accepting cycle
// CHECK    | Z==0 -> point at infinity, else issue inverter request
// INV_WAIT | inv_start held until inverter reports done
// MUL_X    | load multiplier with X, Z^-1
// MUL_X_W  | wait MUL_LAT cycles, capture x_aff
// MUL_Y    | load multiplier with Y, Z^-1 or Z^-2
// MUL_Y_W  | wait MUL_LAT cycles, capture y_aff
// FIN      | wait for inverter done to fall, then pulse done
module gf2m_proj2aff571
    import gf571_pkg::*;
#(
    parameter bit COORD   = 1'b1,
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    gf2m_proj2aff571_if.slave    bus
);

    localparam logic [7:0] CNT_LAST = 8'(MUL_LAT - 1);

    conv_state_t  state, state_nxt;

    logic [M-1:0] x_reg, y_reg, z_reg;
    logic [M-1:0] zi, zi_sq;
    logic [M-1:0] mul_a, mul_b, mul_p;
    logic [7:0]   cnt;
    logic         cnt_last;

    logic [M-1:0] x_aff_q, y_aff_q, inv_a_q;
    logic         done_q, err_q, inv_start_q;

    assign cnt_last = (cnt == CNT_LAST);

    gf2m_mult571 #(.LAT(MUL_LAT)) u_mult (
        .clk (clk),
        .rst (rst),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    squerer_571 u_sq (
        .a (zi),
        .y (zi_sq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.start)    state_nxt = CHECK;
            CHECK:    state_nxt = (z_reg == '0) ? FIN : INV_WAIT;
            INV_WAIT: if (bus.inv_done) state_nxt = MUL_X;
            MUL_X:    state_nxt = MUL_X_W;
            MUL_X_W:  if (cnt_last)     state_nxt = MUL_Y;
            MUL_Y:    state_nxt = MUL_Y_W;
            MUL_Y_W:  if (cnt_last)     state_nxt = FIN;
            FIN:      if (!bus.inv_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg       <= '0;
            y_reg       <= '0;
            z_reg       <= '0;
            zi          <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            cnt         <= '0;
            x_aff_q     <= '0;
            y_aff_q     <= '0;
            inv_a_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            inv_start_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_reg <= bus.X;
                        y_reg <= bus.Y;
                        z_reg <= bus.Z;
                        err_q <= 1'b0;
                    end
                end
                CHECK: begin
                    if (z_reg == '0) begin
                        x_aff_q <= '0;
                        y_aff_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        inv_a_q     <= z_reg;
                        inv_start_q <= 1'b1;
                    end
                end
                INV_WAIT: begin
                    // Dropping start is what lets the inverter return to idle.
                    if (bus.inv_done) begin
                        zi          <= bus.inv_result;
                        inv_start_q <= 1'b0;
                    end
                end
                MUL_X: begin
                    mul_a <= x_reg;
                    mul_b <= zi;
                    cnt   <= '0;
                end
                MUL_X_W: begin
                    cnt <= cnt + 8'd1;
                    if (cnt_last) begin
                        x_aff_q <= mul_p;
                    end
                end
                MUL_Y: begin
                    mul_a <= y_reg;
                    mul_b <= COORD ? zi_sq : zi;
                    cnt   <= '0;
                end
                MUL_Y_W: begin
                    cnt <= cnt + 8'd1;
                    if (cnt_last) begin
                        y_aff_q <= mul_p;
                    end
                end
                FIN: begin
                    if (!bus.inv_done) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.x_aff     = x_aff_q;
    assign bus.y_aff     = y_aff_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.inv_start = inv_start_q;
    assign bus.inv_a     = inv_a_q;

endmodule

// File: doc/gf2m_proj2aff571.md
# gf2m_proj2aff571

Projective-to-affine converter for GF(2^571) (x^571 + x^10 + x^5 + x^2 + 1) points, and the client side of the gf2m_inv571 start/done handshake. It takes a point (X, Y, Z), obtains Z^-1 from the shared Itoh-Tsujii inverter, and finishes the conversion with the field multiplier and squarer. It sits between the scalar-multiplication core and the result output stage.

## Interface
- COORD, default 1, coordinate system: 0 = standard projective (y = Y/Z); 1 = López-Dahab (y = Y/Z^2).
- MUL_LAT, default 4, number of cycles from the gf2m_mult571 operand-register load to the cycle its result is captured.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  conversion request; sampled only in IDLE.
- X, Y, Z  in  571 each  projective input point; sampled on the start cycle.
- x_aff, y_aff  out  571 each  affine result; held until the next accepted start.
- done  out  1  one-cycle pulse when x_aff/y_aff/err are valid.
- err  out  1  Z was zero (point at infinity); valid with done, held until the next start.
- busy  out  1  high whenever state != IDLE.
- inv_start  out  1  request to the inverter.
- inv_a  out  571  inverter operand (Z).
- inv_result  in  571  inverter result.
- inv_done  in  1  inverter done level.

## Operation
- Reset values: x_aff=0, y_aff=0, done=0, err=0, busy=0, inv_start=0, inv_a=0, state=IDLE.
- IDLE: on start=1, latch X, Y, Z, clear err, go to CHECK.
- CHECK:
  - If Z==0: x_aff=0, y_aff=0, err=1, go to FIN. inv_start is never asserted on this path.
  - Otherwise: inv_a<=Z, inv_start<=1, go to INV_WAIT.
- INV_WAIT: hold inv_start=1 and inv_a stable until inv_done=1.
  - In that cycle: zi<=inv_result, inv_start<=0, go to MUL_X.
  - The inverter holds done while start is high and returns to idle after start drops, so releasing inv_start is mandatory.
- MUL_X: mul_a<=X, mul_b<=zi, counter<=0, go to MUL_X_W.
- MUL_X_W: count MUL_LAT cycles. On the last one, x_aff<=mul result, go to MUL_Y.
- MUL_Y: mul_a<=Y, mul_b<=(COORD ? squarer(zi) : zi), go to MUL_Y_W. The squarer is combinational, driven from the zi register.
- MUL_Y_W: count MUL_LAT cycles. On the last one, y_aff<=mul result, go to FIN.
- FIN: wait for inv_done==0 (guards re-issue; normally already low). Then pulse done=1 and go to IDLE.
- start while busy: ignored, with no queueing.
- Arithmetic: all values are 571-bit polynomial basis. Addition is XOR; no carries.

## Timing
- Normal path:
  - start sampled in cycle 0.
  - CHECK in cycle 1; inv_start high from cycle 2.
  - If inv_done is first seen high in cycle t, inv_start is low in cycle t+1.
  - done is high in cycle t + 2*MUL_LAT + 4 (t+12 at the default).
- Z==0 path: done=1, err=1 in cycle 3.
- done is high for exactly one cycle. busy falls in the same cycle done rises.
- Reset mid-operation (any state): next cycle state=IDLE, inv_start=0, busy=0, done=0, and outputs are cleared. The inverter shares rst at the top level, so it resets in lockstep.
- A new start is accepted in the cycle after done, i.e. the first IDLE cycle.

## Structure
- Shared package gf571_pkg holds:
  - M=571 and the field polynomial constant;
  - the MUL_LAT default;
  - the converter state enum (IDLE, CHECK, INV_WAIT, MUL_X, MUL_X_W, MUL_Y, MUL_Y_W, FIN).
- Instantiates the existing gf2m_mult571 and squerer_571.
- The gf2m_inv571 instance sits outside this block (shared with other clients); it is wired only through the inv_* ports.
- No new sub-module.

## Test plan
- Identity: X=0x5, Y=0x7, Z=1, COORD=1 -> x_aff=0x5, y_aff=0x7, err=0, one-cycle done.
- Small divide: X=0x6, Y=0x8, Z=0x2, COORD=1 -> x_aff=0x3, y_aff=0x2. With COORD=0 -> y_aff=0x4.
- Infinity: Z=0 -> err=1, x_aff=y_aff=0, done in cycle 3, inv_start never asserted.
- Handshake timing: bench inverter model with done after 30 cycles, held while start is high.
  - inv_start drops the cycle after inv_done.
  - done arrives exactly 2*MUL_LAT+4 cycles after inv_done is first seen.
  - busy is high throughout.
- Robustness:
  - start pulsed again while in INV_WAIT -> ignored; one done per accepted start.
  - rst asserted in MUL_X_W -> all outputs 0 next cycle; a subsequent conversion is correct.
- Random: 200 random nonzero Z against the real gf2m_inv571 -> x_aff*Z==X and y_aff*Z^2==Y (COORD=1), checked with a software GF(2^571) model.
